// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : display_scan_ctrl
// Brief   : 8-digit common-anode 7-segment scan controller with blanking gap.
// Revision: 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 8,
    parameter int DIV_W     = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] digits_in,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    output logic [2:0]  rr,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] C_BLANK_LAST = DIV_W'(BLANK_CYC - 1);
    localparam logic [DIV_W-1:0] C_SLOT_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] C_ONE        = DIV_W'(1);

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;

    logic [3:0] w_nib;
    logic       w_den;
    logic       w_dp;
    logic [7:0] w_an_lit;
    logic [6:0] w_seg;

    assign w_nib    = digits_in[{rr, 2'b00} +: 4];
    assign w_den    = digit_en[rr];
    assign w_dp     = dp_in[rr];
    assign w_an_lit = ~(8'h80 >> rr);

    // Segment patterns are {g,f,e,d,c,b,a}, active-low
    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            4'hF: w_seg = 7'b0001110;
            default: w_seg = 7'h7F;
        endcase
    end

    // The output registers double as the per-slot holding registers: they are
    // loaded once on entry to SHOW and left untouched until the slot ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            rr         <= 3'd0;
            AN         <= 8'hFF;
            SEG        <= 7'h7F;
            DP         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    AN    <= 8'hFF;
                    SEG   <= 7'h7F;
                    DP    <= 1'b1;
                    rr    <= 3'd0;
                    r_cnt <= '0;
                    if (en) begin
                        r_state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    AN  <= 8'hFF;
                    SEG <= 7'h7F;
                    DP  <= 1'b1;
                    if (!en) begin
                        r_state <= ST_IDLE;
                        rr      <= 3'd0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                        if (r_cnt == C_BLANK_LAST) begin
                            r_state <= ST_SHOW;
                            if (w_den) begin
                                AN  <= w_an_lit;
                                SEG <= w_seg;
                                DP  <= ~w_dp;
                            end
                        end
                    end
                end
                ST_SHOW: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                        rr      <= 3'd0;
                        r_cnt   <= '0;
                        AN      <= 8'hFF;
                        SEG     <= 7'h7F;
                        DP      <= 1'b1;
                    end else if (r_cnt == C_SLOT_LAST) begin
                        r_state    <= ST_BLANK;
                        r_cnt      <= '0;
                        rr         <= rr + 3'd1;
                        AN         <= 8'hFF;
                        SEG        <= 7'h7F;
                        DP         <= 1'b1;
                        frame_done <= (rr == 3'd7);
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_display_scan_ctrl
// Brief   : Randomized bench for display_scan_ctrl against a timeline model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int CLK_DIV   = 10;
    localparam int BLANK_CYC = 2;
    localparam int DIV_W     = 17;
    localparam int FRAME     = 8 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] digits_in;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic [2:0]  rr;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    display_scan_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .BLANK_CYC(BLANK_CYC),
        .DIV_W    (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digits_in (digits_in),
        .digit_en  (digit_en),
        .dp_in     (dp_in),
        .rr        (rr),
        .AN        (AN),
        .SEG       (SEG),
        .DP        (DP),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Model: scanning is a timeline t counted from the first BLANK cycle
    bit       m_on = 1'b0;
    int       m_t  = 0;
    logic [3:0] m_nib = 4'h0;
    bit       m_den = 1'b0;
    bit       m_dp  = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic int slot_now();
        return (m_t / CLK_DIV) % 8;
    endfunction

    function automatic int pos_now();
        return m_t % CLK_DIV;
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [2:0] s;
        logic       fd;
        if (!m_on) return {3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0};
        s  = 3'(slot_now());
        fd = (m_t > 0) && (m_t % FRAME == 0);
        if (pos_now() < BLANK_CYC || !m_den) return {s, 8'hFF, 7'h7F, 1'b1, fd};
        return {s, 8'hFF & ~(8'd1 << (7 - slot_now())), seg_of(m_nib), ~m_dp, fd};
    endfunction

    function automatic logic [19:0] obs();
        return {rr, AN, SEG, DP, frame_done};
    endfunction

    task automatic model_step();
        int s;
        if (!rst_n) begin
            m_on = 1'b0;
        end else if (!m_on) begin
            if (en) begin
                m_on = 1'b1;
                m_t  = 0;
            end
        end else if (!en) begin
            m_on = 1'b0;
        end else begin
            m_t++;
            if (pos_now() == BLANK_CYC) begin
                s     = slot_now();
                m_nib = digits_in[s*4 +: 4];
                m_den = digit_en[s];
                m_dp  = dp_in[s];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        total++;
        if ($countones(~AN) > 1) begin
            bad++;
            $display("FAIL onehot AN=%b required at most one low bit", AN);
        end
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        en        = 1'b1;
        digits_in = $urandom;
        digit_en  = 8'hFF;
        dp_in     = 8'($urandom);
        repeat (3) begin
            tick();
            total++;
            if (obs() !== {3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL reset got=%h required=%h", obs(), {3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_startup();
        int lit0 = 0;
        rst_n = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            total++;
            if (obs() !== exp_vec()) begin
                bad++;
                $display("FAIL startup cyc=%0d got=%h required=%h", i, obs(), exp_vec());
            end
            if (i <= 12 && AN == 8'h7F) lit0++;
            if (i == 13) begin
                total++;
                if (AN !== 8'hBF || rr !== 3'd1) begin
                    bad++;
                    $display("FAIL startup_slot1 AN=%h rr=%0d required AN=bf rr=1", AN, rr);
                end
            end
        end
        total++;
        if (lit0 != CLK_DIV - BLANK_CYC) begin
            bad++;
            $display("FAIL startup_lit0 got=%0d required=%0d", lit0, CLK_DIV - BLANK_CYC);
        end
    endtask

    task automatic test_frame();
        int pulses = 0;
        int at     = 0;
        rst_n = 1'b0;
        tick();
        digits_in = 32'h76543210;
        digit_en  = 8'hFF;
        dp_in     = 8'h01;
        rst_n     = 1'b1;
        for (int i = 1; i <= FRAME + 6; i++) begin
            tick();
            total++;
            if (obs() !== exp_vec()) begin
                bad++;
                $display("FAIL frame cyc=%0d got=%h required=%h", i, obs(), exp_vec());
            end
            if (frame_done === 1'b1) begin
                pulses++;
                at = i - 1;
            end
        end
        total++;
        if (pulses != 1 || at != FRAME) begin
            bad++;
            $display("FAIL frame_done pulses=%0d at=%0d required 1 at %0d", pulses, at, FRAME);
        end
    endtask

    task automatic test_digit_en();
        digit_en  = 8'b11111011;
        digits_in = $urandom;
        dp_in     = 8'($urandom);
        for (int i = 0; i < FRAME + CLK_DIV; i++) begin
            tick();
            total++;
            if (obs() !== exp_vec()) begin
                bad++;
                $display("FAIL digit_en cyc=%0d got=%h required=%h", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_hold();
        bit hit = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
        digits_in = 32'h0;
        digit_en  = 8'hFF;
        dp_in     = 8'($urandom);
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            tick();
            total++;
            if (obs() !== exp_vec()) begin
                bad++;
                $display("FAIL hold_pre got=%h required=%h", obs(), exp_vec());
            end
            if (m_on && slot_now() == 3 && pos_now() == 5) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL hold_reach reached=%0d required=1", hit);
        end
        digits_in = 32'hFFFF_FFFF;
        for (int i = 0; i < FRAME + CLK_DIV; i++) begin
            tick();
            total++;
            if (obs() !== exp_vec()) begin
                bad++;
                $display("FAIL hold cyc=%0d got=%h required=%h", i, obs(), exp_vec());
            end
            if (i < CLK_DIV - 6) begin
                total++;
                if (SEG !== 7'b1000000) begin
                    bad++;
                    $display("FAIL hold_seg got=%b required=1000000", SEG);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        bit hit = 1'b0;
        digits_in = $urandom;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            tick();
            total++;
            if (obs() !== exp_vec()) begin
                bad++;
                $display("FAIL en_pre got=%h required=%h", obs(), exp_vec());
            end
            if (m_on && slot_now() == 5 && pos_now() == 6) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL en_reach reached=%0d required=1", hit);
        end
        en = 1'b0;
        tick();
        total++;
        if (AN !== 8'hFF || rr !== 3'd0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL en_drop AN=%h rr=%0d fd=%b required AN=ff rr=0 fd=0", AN, rr, frame_done);
        end
        for (int i = 0; i < 3 + 2 * CLK_DIV; i++) begin
            if (i == 3) en = 1'b1;
            tick();
            total++;
            if (obs() !== exp_vec()) begin
                bad++;
                $display("FAIL en_restart cyc=%0d got=%h required=%h", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            tick();
            if (m_on && slot_now() == 4 && pos_now() == 4) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rst_reach reached=%0d required=1", hit);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if (obs() !== {3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid got=%h required=%h", obs(), {3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            tick();
            total++;
            if (obs() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_resume cyc=%0d got=%h required=%h", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            digits_in = $urandom;
            dp_in     = 8'($urandom);
            digit_en  = 8'($urandom);
            if ($urandom_range(0, 199) == 0) en = ~en;
            if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
            total++;
            if (obs() !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h required=%h", i, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_frame();
        test_digit_en();
        test_hold();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit common-anode 7-segment display. It steps the 3-bit digit index `rr` through digits 0..7 at a programmable rate and drives the active-low anode lines `AN` directly. It inserts an all-anodes-off blanking gap before each digit to suppress ghosting, and decodes the selected 4-bit digit value to active-low segments. It sits between the alarm/time datapath (packed BCD/hex nibbles) and the board display pins.

Parameters:
CLK_DIV, 100000, clk cycles per digit slot including blanking (1 kHz per digit at 100 MHz); legal range CLK_DIV >= BLANK_CYC+2.
BLANK_CYC, 8, cycles per slot with all anodes off, at the start of each slot; legal range >= 1.
DIV_W, 17, counter width; must satisfy 2^DIV_W > CLK_DIV.

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
en  in  1  scan enable; 0 forces the display dark
digits_in  in  32  8 nibbles; digit k = digits_in[4k+3:4k]
digit_en  in  8  per-digit enable; 0 keeps that digit dark during its slot
dp_in  in  8  per-digit decimal point request, active-high
rr  out  3  current digit index
AN  out  8  anode drive, active-low one-hot
SEG  out  7  segments {g,f,e,d,c,b,a}, active-low
DP  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse at the end of the digit-7 slot

Behaviour:
- Reset: rst_n=0 sampled at posedge sets state=IDLE, cnt=0, rr=0, AN=8'hFF, SEG=7'h7F, DP=1, frame_done=0. Reset applies mid-slot and mid-frame with no residue.
- States: IDLE, BLANK, SHOW. All outputs are registered.
- IDLE: outputs dark. If en=1, go to BLANK next cycle with rr=0 and cnt=0.
- BLANK: AN=8'hFF, SEG=7'h7F, DP=1. cnt counts 0..BLANK_CYC-1. At cnt=BLANK_CYC-1, go to SHOW.
- On the BLANK->SHOW transition, capture nibble rr of digits_in, digit_en[rr] and dp_in[rr] into holding registers. Input changes during SHOW have no effect until the next slot.
- SHOW, cnt continues BLANK_CYC..CLK_DIV-1:
  - If the captured enable=1: AN has bit (7-rr) low and all others high (rr=0 gives 8'b01111111, rr=7 gives 8'b11111110). SEG = decode(nibble). DP = ~dp.
  - If the captured enable=0: AN=8'hFF, SEG=7'h7F, DP=1.
- End of SHOW (cnt=CLK_DIV-1): cnt<=0, rr<=rr+1 (wraps 7->0), go to BLANK. If rr was 7, frame_done=1 for exactly that following cycle.
- Slot period is exactly CLK_DIV cycles: BLANK_CYC dark, CLK_DIV-BLANK_CYC lit. Frame period is 8*CLK_DIV.
- en=0 in BLANK or SHOW: go to IDLE next cycle with outputs dark and rr reset to 0. No frame_done pulse. Re-enable restarts at digit 0.
- Decode table (hex), SEG {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Anodes are never low during BLANK or IDLE. At most one AN bit is low in any cycle.

Test Plan:
1. Run with CLK_DIV=10, BLANK_CYC=2. Hold rst_n=0 for 3 cycles with en=1 → AN=FF, SEG=7F, DP=1, rr=0. Release → 2 dark cycles, then AN=7F for 8 cycles, then 2 dark cycles, then AN=BF with rr=1.
2. Set digits_in=32'h76543210, digit_en=FF, dp_in=8'h01 and run one frame → slot 0: SEG=1000000, DP=0. Slot 1: SEG=1111001, DP=1. Slot 7: AN=FE, SEG=1111000. frame_done pulses once, 80 cycles after the first BLANK entry. rr wraps to 0.
3. Set digit_en=8'b11111011 → in slot 2, AN=FF and SEG=7F for all 10 cycles. All other slots are lit normally.
4. Change digits_in from 0 to F mid-SHOW of slot 3 → SEG is unchanged for the rest of slot 3. The new value appears only when that digit's next slot begins.
5. Drop en=0 during slot 5 SHOW → next cycle AN=FF and rr=0, with no frame_done. Re-assert en → restart at digit 0 after BLANK_CYC dark cycles.
6. Pulse rst_n=0 for 1 cycle mid-slot 4 → all outputs at reset values next cycle. Scanning restarts from rr=0. Across all cycles, a checker asserts at most one AN bit is low.
